data_mem_ctrl: RTL and testbench

Parametrised data-memory block for the core's load/store port; the next generation of the plain RAM on the data side. It adds a valid/ready request/response handshake, byte-lane writes and a configurable read latency of 1..4 cycles. It reports out-of-range accesses as errors. The block sits between core (daddr/ddata_w/ddata_r) and on-chip storage and holds at most one transaction in flight.

---
 rtl/data_mem_ctrl_if.sv | 31 +++
 rtl/data_mem_ctrl.sv | 133 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the core load/store port and data_mem_ctrl.
// Latency: none (wires only).
// Backpressure: valid/ready on both request and response channels.
interface data_mem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  busy;

    // Requester / response consumer side
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    // Memory controller side
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory with valid/ready request/response, byte-lane writes, range error reporting.
// Latency: write ack visible the cycle after acceptance; read data after RD_LATENCY (1..4) cycles.
// Backpressure: one transaction in flight; req_ready low from acceptance until the response handshake.
module data_mem_ctrl #(
    parameter int          DATA_W     = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int          ADDR_W     = $clog2(DEPTH),
    parameter int          RD_LATENCY = 1
) (
    input logic               CLK,
    input logic               RESET,
    data_mem_ctrl_if.slave    bus
);
    localparam int NB = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;

    logic accept;
    logic in_range;

    assign accept   = bus.req_valid && req_ready_q;
    assign in_range = (32'(bus.req_addr) < DEPTH);

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.busy      = busy_q;

    // Storage: in-range writes commit their enabled byte lanes on the acceptance edge
    always_ff @(posedge CLK) begin
        if (accept && bus.req_we && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.req_be[i]) begin
                    mem[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Next-state and registered-output computation for the transaction FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d = bus.req_addr;
                    err_d  = !in_range;
                    if (bus.req_we || RD_LATENCY == 1) begin
                        // Writes and single-cycle reads respond straight away
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rdata_d     = (!bus.req_we && in_range) ? mem[bus.req_addr] : '0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 3'(RD_LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd1) begin
                    // Data is sampled on the last wait edge, so a late write cannot leak in
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rdata_d     = err_q ? '0 : mem[addr_q];
                    cnt_d       = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rdata_d     = '0;
                    err_d       = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                rdata_d     = '0;
                err_d       = 1'b0;
                cnt_d       = 3'd0;
            end
        endcase
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // FSM state and registered outputs; reset drops any pending response
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: four instances with RD_LATENCY 1..4, DEPTH 1000.
// Latency: checks response timing per instance.
// Backpressure: exercises rsp_ready hold-off and mid-transaction reset.
module tb_data_mem_ctrl;
    localparam int ND = 4;
    localparam int NV = 20;

    logic CLK;
    logic RESET;

    logic [ND-1:0]       req_valid;
    logic [ND-1:0]       req_we;
    logic [ND-1:0][9:0]  req_addr;
    logic [ND-1:0][31:0] req_wdata;
    logic [ND-1:0][3:0]  req_be;
    logic [ND-1:0]       rsp_ready;
    logic [ND-1:0]       req_ready;
    logic [ND-1:0]       rsp_valid;
    logic [ND-1:0][31:0] rsp_rdata;
    logic [ND-1:0]       rsp_err;
    logic [ND-1:0]       busy;

    int checks   = 0;
    int failures = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(10)) bus ();
        assign bus.req_valid = req_valid[g];
        assign bus.req_we    = req_we[g];
        assign bus.req_addr  = req_addr[g];
        assign bus.req_wdata = req_wdata[g];
        assign bus.req_be    = req_be[g];
        assign bus.rsp_ready = rsp_ready[g];
        assign req_ready[g]  = bus.req_ready;
        assign rsp_valid[g]  = bus.rsp_valid;
        assign rsp_rdata[g]  = bus.rsp_rdata;
        assign rsp_err[g]    = bus.rsp_err;
        assign busy[g]       = bus.busy;

        data_mem_ctrl #(
            .DATA_W(32), .DEPTH(1000), .ADDR_W(10), .RD_LATENCY(g + 1)
        ) u_dut (
            .CLK   (CLK),
            .RESET (RESET),
            .bus   (bus.slave)
        );
    end

    typedef struct {
        int          d;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          d;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    vec_t tbl [NV];
    exp_t sb_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Issue one request, track its expected response in the scoreboard, check timing and data
    task automatic do_req(input vec_t v, input int idx);
        int   d;
        int   n;
        int   k;
        exp_t e;
        string tag;
        d   = v.d;
        tag = $sformatf("v%0d_d%0d", idx, d);
        @(negedge CLK);
        req_valid[d] = 1'b1;
        req_we[d]    = v.we;
        req_addr[d]  = v.addr;
        req_wdata[d] = v.wdata;
        req_be[d]    = v.be;
        rsp_ready[d] = (v.hold == 0);
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_accept_ready"}, 32'(req_ready[d]), 32'd1);
        if (!req_ready[d]) begin
            req_valid[d] = 1'b0;
            return;
        end
        sb_q.push_back('{d: d, rdata: v.exp_rdata, err: v.exp_err, lat: (v.we ? 1 : d + 1)});
        @(posedge CLK);
        #1;
        req_valid[d] = 1'b0;
        k = 1;
        while (!rsp_valid[d] && k < 12) begin
            chk({tag, "_wait_busy"},  32'(busy[d]),      32'd1);
            chk({tag, "_wait_ready"}, 32'(req_ready[d]), 32'd0);
            @(posedge CLK);
            #1;
            k++;
        end
        e = sb_q.pop_front();
        chk({tag, "_latency"}, 32'(k), 32'(e.lat));
        chk({tag, "_rdata"},   rsp_rdata[d],     e.rdata);
        chk({tag, "_err"},     32'(rsp_err[d]),  32'(e.err));
        chk({tag, "_busy"},    32'(busy[d]),     32'd1);
        for (int h = 0; h < v.hold; h++) begin
            @(posedge CLK);
            #1;
            chk({tag, "_hold_valid"}, 32'(rsp_valid[d]), 32'd1);
            chk({tag, "_hold_rdata"}, rsp_rdata[d],      e.rdata);
            chk({tag, "_hold_err"},   32'(rsp_err[d]),   32'(e.err));
            chk({tag, "_hold_ready"}, 32'(req_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(posedge CLK);
        #1;
        chk({tag, "_post_valid"}, 32'(rsp_valid[d]), 32'd0);
        chk({tag, "_post_ready"}, 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET     = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = '1;

        //        d  we addr     wdata          be    hold exp_rdata     err
        tbl[0]  = '{0, 1, 10'd5,   32'hDEADBEEF, 4'hF, 0, 32'h0,        1'b0};
        tbl[1]  = '{0, 0, 10'd5,   32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{0, 1, 10'd9,   32'h11223344, 4'hF, 0, 32'h0,        1'b0};
        tbl[3]  = '{0, 1, 10'd9,   32'hAABBCCDD, 4'h5, 0, 32'h0,        1'b0};
        tbl[4]  = '{0, 0, 10'd9,   32'h0,        4'h0, 0, 32'h11BB33DD, 1'b0};
        tbl[5]  = '{0, 1, 10'd9,   32'hFFFFFFFF, 4'h0, 0, 32'h0,        1'b0};
        tbl[6]  = '{0, 0, 10'd9,   32'h0,        4'h0, 0, 32'h11BB33DD, 1'b0};
        tbl[7]  = '{1, 1, 10'd7,   32'hCAFEF00D, 4'hF, 0, 32'h0,        1'b0};
        tbl[8]  = '{1, 0, 10'd7,   32'h0,        4'h0, 0, 32'hCAFEF00D, 1'b0};
        tbl[9]  = '{2, 1, 10'd7,   32'h12345678, 4'hF, 0, 32'h0,        1'b0};
        tbl[10] = '{2, 0, 10'd7,   32'h0,        4'h0, 0, 32'h12345678, 1'b0};
        tbl[11] = '{3, 1, 10'd3,   32'hA5A5A5A5, 4'hF, 0, 32'h0,        1'b0};
        tbl[12] = '{3, 0, 10'd3,   32'h0,        4'h0, 0, 32'hA5A5A5A5, 1'b0};
        tbl[13] = '{0, 1, 10'd999, 32'h55AA55AA, 4'hF, 0, 32'h0,        1'b0};
        tbl[14] = '{0, 0, 10'd1000,32'h0,        4'h0, 0, 32'h0,        1'b1};
        tbl[15] = '{0, 1, 10'd1023,32'h77777777, 4'hF, 0, 32'h0,        1'b1};
        tbl[16] = '{0, 0, 10'd999, 32'h0,        4'h0, 0, 32'h55AA55AA, 1'b0};
        tbl[17] = '{3, 0, 10'd1000,32'h0,        4'h0, 0, 32'h0,        1'b1};
        tbl[18] = '{1, 0, 10'd7,   32'h0,        4'h0, 5, 32'hCAFEF00D, 1'b0};
        tbl[19] = '{2, 1, 10'd1000,32'h0,        4'hF, 3, 32'h0,        1'b1};

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_err",       32'(rsp_err),   32'h0);
        chk("rst_rdata0",    rsp_rdata[0],   32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'hF);

        for (int i = 0; i < NV; i++) begin
            do_req(tbl[i], i);
        end

        // Reset two cycles into a latency-4 read: response must be dropped
        @(negedge CLK);
        req_valid[3] = 1'b1;
        req_we[3]    = 1'b0;
        req_addr[3]  = 10'd3;
        rsp_ready[3] = 1'b1;
        chk("midrst_ready_before", 32'(req_ready[3]), 32'd1);
        @(posedge CLK);
        #1;
        req_valid[3] = 1'b0;
        chk("midrst_busy_inflight", 32'(busy[3]), 32'd1);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        #1;
        chk("midrst_valid", 32'(rsp_valid[3]), 32'd0);
        chk("midrst_busy",  32'(busy[3]),      32'd0);
        chk("midrst_ready", 32'(req_ready[3]), 32'd0);
        chk("midrst_rdata", rsp_rdata[3],      32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge CLK);
            #1;
            chk("midrst_no_rsp", 32'(rsp_valid[3]), 32'd0);
        end
        do_req('{3, 0, 10'd3, 32'h0, 4'h0, 0, 32'hA5A5A5A5, 1'b0}, 100);
        do_req('{0, 0, 10'd5, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0}, 101);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
